pwm_capture: RTL

- Measures an incoming PWM waveform: high time, period and duty cycle.
- Duty is quantised to R bits, the same resolution used by the team's PWM generators, so a generator's output can be looped back and checked in hardware.
- Sits between an external/loopback PWM pin and the control/status logic.
- Contains the input synchroniser, a tick prescaler, an edge-timing FSM and a sequential restoring divider.

---
 rtl/pwm_capture_if.sv | 26 ++
 rtl/pwm_capture.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// Measurement-side signal bundle of pwm_capture: PWM pin and restart in, results and status out.
interface pwm_capture_if #(
  parameter int W = 16,
  parameter int R = 5
) ();
  logic         pwm_in;
  logic         clear;
  logic [W-1:0] high_cnt;
  logic [W-1:0] period_cnt;
  logic [R-1:0] duty;
  logic         valid;
  logic         busy;
  logic         stuck_hi;
  logic         stuck_lo;
  logic         overrun;

  modport master (
    output pwm_in, clear,
    input  high_cnt, period_cnt, duty, valid, busy, stuck_hi, stuck_lo, overrun
  );

  modport slave (
    input  pwm_in, clear,
    output high_cnt, period_cnt, duty, valid, busy, stuck_hi, stuck_lo, overrun
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM measurement: synchroniser, tick prescaler, edge-timing FSM and restoring divider
// producing high time, period and duty = floor(high * 2^R / period).
//
// state | meaning
// IDLE  | not armed; the next rise starts timing a high phase
// HIGH  | input high; counting the high phase
// LOW   | input low; counting the rest of the period
module pwm_capture #(
  parameter int W = 16,
  parameter int R = 5,
  parameter int F = 0
) (
  input logic          clk,
  input logic          reset,
  pwm_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam int SW = $clog2(R + 1);

  state_t        state, state_nxt;
  logic          sync1, sync2, sync3;
  logic          rise, fall, tick;
  logic [W-1:0]  cnt, cnt_cap, h_lat;
  logic          cap_h, start_div, set_ovr, set_shi, set_slo;
  logic          stuck_hi_r, stuck_lo_r, overrun_r;

  logic          div_busy, div_load, div_last, div_free, q_bit;
  logic [SW-1:0] step;
  logic [W-1:0]  d_h, d_p, rem, rem_nxt;
  logic [W:0]    rem_sh;
  logic [R-2:0]  q;
  logic [R-1:0]  q_nxt;
  logic [W-1:0]  high_r, period_r;
  logic [R-1:0]  duty_r;
  logic          valid_r;

  // Two-flop synchroniser followed by the edge-detect flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         {sync1, sync2, sync3} <= '0;
    else if (bus.clear) {sync1, sync2, sync3} <= '0;
    else                {sync1, sync2, sync3} <= {bus.pwm_in, sync1, sync2};
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  generate
    if (F == 0) begin : g_no_pre
      assign tick = 1'b1;
    end else begin : g_pre
      logic [F-1:0] pre;
      // Free-running prescaler; clear leaves it alone so the tick phase survives a restart
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) pre <= '0;
        else        pre <= pre + 1'b1;
      end
      assign tick = &pre;
    end
  endgenerate

  // cnt_cap is both the saturating next count and the value captured on an edge
  assign cnt_cap = (cnt == CNT_MAX) ? cnt : cnt + W'(tick);

  // Tick counter: restarts on every rise, otherwise counts ticks up to saturation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         cnt <= '0;
    else if (bus.clear) cnt <= '0;
    else if (rise)      cnt <= '0;
    else                cnt <= cnt_cap;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         state <= IDLE;
    else if (bus.clear) state <= IDLE;
    else                state <= state_nxt;
  end

  // FSM next state and capture/status strobes
  always_comb begin
    state_nxt = state;
    cap_h     = 1'b0;
    start_div = 1'b0;
    set_ovr   = 1'b0;
    set_shi   = 1'b0;
    set_slo   = 1'b0;
    case (state)
      IDLE: if (rise) state_nxt = HIGH;
      HIGH: begin
        if (fall) begin
          cap_h     = 1'b1;
          state_nxt = LOW;
        end else if (cnt == CNT_MAX) begin
          set_shi   = 1'b1;
          state_nxt = IDLE;
        end
      end
      LOW: begin
        if (rise) begin
          if (div_free) start_div = 1'b1;
          else          set_ovr   = 1'b1;
          state_nxt = HIGH;
        end else if (cnt == CNT_MAX) begin
          set_slo   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // High-time latch and status flags; stuck flags clear on the edge that ends them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_lat      <= '0;
      stuck_hi_r <= 1'b0;
      stuck_lo_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else if (bus.clear) begin
      h_lat      <= '0;
      stuck_hi_r <= 1'b0;
      stuck_lo_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (cap_h) h_lat <= cnt_cap;
      if (fall)         stuck_hi_r <= 1'b0;
      else if (set_shi) stuck_hi_r <= 1'b1;
      if (rise)         stuck_lo_r <= 1'b0;
      else if (set_slo) stuck_lo_r <= 1'b1;
      if (set_ovr) overrun_r <= 1'b1;
    end
  end

  // The finishing iteration frees the divider, so a rise on that cycle restarts it
  assign div_last = div_busy & ~div_load & (step == SW'(R - 1));
  assign div_free = ~div_busy | div_last;
  assign rem_sh   = {rem, 1'b0};
  assign q_bit    = (rem_sh >= {1'b0, d_p});
  assign rem_nxt  = q_bit ? W'(rem_sh - {1'b0, d_p}) : rem_sh[W-1:0];
  assign q_nxt    = {q, q_bit};

  // Divider: one load cycle then R restoring iterations; results commit on the last one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {div_busy, div_load, step, d_h, d_p, rem, q} <= '0;
      {high_r, period_r, duty_r, valid_r}          <= '0;
    end else if (bus.clear) begin
      {div_busy, div_load, step, d_h, d_p, rem, q} <= '0;
      {high_r, period_r, duty_r, valid_r}          <= '0;
    end else begin
      valid_r <= div_last;
      if (div_last) begin
        high_r   <= d_h;
        period_r <= d_p;
        duty_r   <= q_nxt;
      end
      if (start_div) begin
        div_busy <= 1'b1;
        div_load <= 1'b1;
        d_h      <= h_lat;
        d_p      <= cnt_cap;
      end else if (div_load) begin
        div_load <= 1'b0;
        rem      <= d_h;
        q        <= '0;
        step     <= '0;
      end else if (div_last) begin
        div_busy <= 1'b0;
      end else if (div_busy) begin
        rem  <= rem_nxt;
        q    <= q_nxt[R-2:0];
        step <= step + 1'b1;
      end
    end
  end

  assign bus.high_cnt   = high_r;
  assign bus.period_cnt = period_r;
  assign bus.duty       = duty_r;
  assign bus.valid      = valid_r;
  assign bus.busy       = div_busy;
  assign bus.stuck_hi   = stuck_hi_r;
  assign bus.stuck_lo   = stuck_lo_r;
  assign bus.overrun    = overrun_r;
endmodule
